command_display_scan: RTL and testbench

Parametrised successor of the static four-digit command display. It latches an {address, command} word from the command buffer and drives a shared seven-segment bus with one-hot digit enables, using time-multiplexing instead of one decoder per digit. Field widths and scan rate are generic. It adds a blinking cursor digit for command entry and a frame-done strobe. It sits between the command-entry logic and the board display pins.

---
 rtl/command_display_scan_pkg.sv | 26 ++
 rtl/hex_disp.sv | 35 +++
 rtl/command_display_scan.sv | 154 +++++++++++++++
 tb/tb_command_display_scan.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/command_display_scan_pkg.sv
// command_display_scan_pkg
// Shared display definitions: the dark segment pattern and the constant
// helpers used to size the digit count, index and counter fields.
package command_display_scan_pkg;

  // Active-low segments: all ones turns every segment off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Number of hex digits needed to show a field of w bits.
  function automatic int ceil_div4(input int w);
    return (w + 32'sd3) / 32'sd4;
  endfunction

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 32'sd1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 32'sd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_disp.sv
// hex_disp
// Hex nibble to seven-segment decoder, active-low outputs.
// Ports:
//   nibble  in  4  value 0..F to display
//   seg     out 7  segments {g,f,e,d,c,b,a}, 0 = segment lit
module hex_disp (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Segment lookup for each hex value.
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/command_display_scan.sv
// command_display_scan
// Time-multiplexed hex display of an {address, command} word with a
// blinking cursor digit and a per-frame strobe.
// Ports:
//   clk         in  1             system clock, rising edge
//   rst         in  1             synchronous active-high reset
//   cmd_buf     in  ADDR_W+CMD_W  {address, command}, address in the MSBs
//   load        in  1             capture cmd_buf into the shadow register
//   cursor_en   in  1             enable cursor blinking
//   cursor_pos  in  IDX_W         cursor digit index, 0 = leftmost
//   blank       in  1             force the whole display dark
//   seg         out 7             registered segments, active-low
//   an          out N_DIG         registered digit enables, active-low one-hot
//   frame_done  out 1             high in the last cycle of the last digit slot
module command_display_scan
  import command_display_scan_pkg::*;
#(
  parameter int ADDR_W       = 32'sd5,
  parameter int CMD_W        = 32'sd7,
  parameter int SCAN_DIV     = 32'sd50000,
  parameter int BLINK_FRAMES = 32'sd64,
  localparam int A_DIG = ceil_div4(ADDR_W),
  localparam int C_DIG = ceil_div4(CMD_W),
  localparam int N_DIG = A_DIG + C_DIG,
  localparam int IDX_W = clog2_min1(N_DIG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W+CMD_W-1:0]  cmd_buf,
  input  logic                     load,
  input  logic                     cursor_en,
  input  logic [IDX_W-1:0]         cursor_pos,
  input  logic                     blank,
  output logic [6:0]               seg,
  output logic [N_DIG-1:0]         an,
  output logic                     frame_done
);

  localparam int A_W   = A_DIG * 32'sd4;
  localparam int C_W   = C_DIG * 32'sd4;
  localparam int SH_W  = N_DIG * 32'sd4;
  localparam int CNT_W = clog2_min1(SCAN_DIV);
  localparam int FR_W  = clog2_min1(BLINK_FRAMES);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 32'sd1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 32'sd1);
  localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(BLINK_FRAMES - 32'sd1);
  localparam logic [N_DIG-1:0] AN_ONE   = {{(N_DIG-1){1'b0}}, 1'b1};

  logic [SH_W-1:0]  shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FR_W-1:0]  fr_q, fr_d;
  logic             ph_q, ph_d;
  logic [N_DIG-1:0] an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             tick_s;
  logic             frame_done_s;
  logic             dark_s;
  logic [3:0]       nib_s;
  logic [6:0]       hex_seg_s;

  // Single decoder shared by all digits through the nibble mux.
  hex_disp u_hex_disp (
    .nibble (nib_s),
    .seg    (hex_seg_s)
  );

  // Scan divider, digit index, blink phase and shadow register next state.
  always_comb begin
    tick_s       = (cnt_q == CNT_LAST);
    frame_done_s = tick_s & (idx_q == IDX_LAST);

    if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (!tick_s) begin
      idx_d = idx_q;
    end else if (idx_q == IDX_LAST) begin
      idx_d = '0;
    end else begin
      idx_d = idx_q + IDX_W'(1);
    end

    fr_d = fr_q;
    ph_d = ph_q;
    if (!frame_done_s) begin
      fr_d = fr_q;
    end else if (fr_q == FR_LAST) begin
      fr_d = '0;
      ph_d = ~ph_q;
    end else begin
      fr_d = fr_q + FR_W'(1);
    end

    // Address and command are each zero-extended to whole nibbles.
    if (load) begin
      shadow_d = {A_W'(cmd_buf[ADDR_W+CMD_W-1:CMD_W]), C_W'(cmd_buf[CMD_W-1:0])};
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Nibble select and dark decision feeding the output registers.
  always_comb begin
    // Digit 0 sits in the top nibble; idx never exceeds N_DIG-1 so exactly
    // one term of the OR is selected.
    nib_s = 4'h0;
    for (int i = 0; i < N_DIG; i++) begin
      nib_s = nib_s | ({4{idx_q == IDX_W'(i)}} & shadow_q[SH_W-1-4*i -: 4]);
    end

    // An out-of-range cursor_pos never equals idx, so it blanks nothing.
    dark_s = blank | (cursor_en & ph_q & (cursor_pos == idx_q));

    if (dark_s) begin
      an_d  = {N_DIG{1'b1}};
      seg_d = SEG_BLANK;
    end else begin
      an_d  = ~(AN_ONE << idx_q);
      seg_d = hex_seg_s;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      fr_q     <= '0;
      ph_q     <= 1'b0;
      an_q     <= {N_DIG{1'b1}};
      seg_q    <= SEG_BLANK;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      fr_q     <= fr_d;
      ph_q     <= ph_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_s;

endmodule

// File: tb/tb_command_display_scan.sv
// Directed bench for command_display_scan: ADDR_W=5, CMD_W=7, SCAN_DIV=4,
// BLINK_FRAMES=2 as the main instance, plus a five-digit instance with
// SCAN_DIV=1 to exercise an out-of-range cursor position.
module tb_command_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] cmd_buf;
  logic        load;
  logic        cursor_en;
  logic [1:0]  cursor_pos;
  logic        blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  logic [16:0] cmd_buf2;
  logic [2:0]  cursor_pos2;
  logic [6:0]  seg2;
  logic [4:0]  an2;
  logic        frame_done2;

  int n;
  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  command_display_scan #(
    .ADDR_W(5), .CMD_W(7), .SCAN_DIV(4), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .cmd_buf(cmd_buf), .load(load),
    .cursor_en(cursor_en), .cursor_pos(cursor_pos), .blank(blank),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  command_display_scan #(
    .ADDR_W(5), .CMD_W(12), .SCAN_DIV(1), .BLINK_FRAMES(1)
  ) dut2 (
    .clk(clk), .rst(rst), .cmd_buf(cmd_buf2), .load(1'b0),
    .cursor_en(1'b1), .cursor_pos(cursor_pos2), .blank(1'b0),
    .seg(seg2), .an(an2), .frame_done(frame_done2)
  );

  // Reference segment table, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  // One clock; n counts edges since the last reset edge; sample on negedge.
  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  // Expected main-instance outputs at edge count n: outputs show the digit
  // whose slot was active one cycle earlier, 4 cycles per slot, 16 per frame,
  // blink phase flips every two frames.
  task automatic check_scan(input string tag, input logic [15:0] sh,
                            input bit cur_en, input int cur_pos, input bit blanked);
    int d;
    int f;
    bit ph;
    bit dark;
    logic [3:0] ea;
    logic [6:0] es;
    logic       efd;
    d    = ((n - 1) / 4) % 4;
    f    = (n - 1) / 16;
    ph   = ((f / 2) % 2) == 1;
    dark = blanked || (cur_en && ph && d == cur_pos);
    ea   = dark ? 4'hF : ~(4'b0001 << d);
    es   = dark ? 7'h7F : hex7(sh[15-4*d -: 4]);
    efd  = (n % 16) == 15;
    check_eq({tag, "_an"}, an, ea);
    check_eq({tag, "_seg"}, seg, es);
    check_eq({tag, "_fd"}, frame_done, efd);
  endtask

  initial begin
    logic [4:0] ea2;
    n = 0; vectors = 0; miscompares = 0;
    rst = 1'b1; load = 1'b0; cmd_buf = 12'h000; cursor_en = 1'b0;
    cursor_pos = 2'd0; blank = 1'b0; cmd_buf2 = 17'h00000; cursor_pos2 = 3'd7;

    step(); step();
    check_eq("rst_an", an, 4'hF);
    check_eq("rst_seg", seg, 7'h7F);
    check_eq("rst_fd", frame_done, 1'b0);

    // Release reset and load 12'hA5B on the first edge: addr 0x14, cmd 0x5B.
    rst = 1'b0; n = 0;
    load = 1'b1; cmd_buf = 12'hA5B; cursor_en = 1'b1; cursor_pos = 2'd2;
    step();
    load = 1'b0;
    check_eq("first_an", an, 4'hE);
    check_eq("first_seg", seg, 7'h40);
    check_eq("first_fd", frame_done, 1'b0);

    // Six frames: digit 2 dark only in frames 2 and 3.
    while (n < 96) begin
      step();
      check_scan("blink", 16'h145B, 1'b1, 2, 1'b0);
    end

    // Load zeros on the edge where idx wraps from the last digit to 0.
    cursor_en = 1'b0;
    while (n < 111) begin
      step();
      check_scan("prewrap", 16'h145B, 1'b0, 0, 1'b0);
    end
    load = 1'b1; cmd_buf = 12'h000;
    step();
    load = 1'b0;
    check_scan("wrapedge", 16'h145B, 1'b0, 0, 1'b0);
    while (n < 128) begin
      step();
      check_scan("afterwrap", 16'h0000, 1'b0, 0, 1'b0);
    end

    // Reload, then blank for ten edges mid-frame.
    load = 1'b1; cmd_buf = 12'hA5B;
    step();
    load = 1'b0;
    check_scan("reload", 16'h0000, 1'b0, 0, 1'b0);
    while (n < 134) begin
      step();
      check_scan("preblank", 16'h145B, 1'b0, 0, 1'b0);
    end
    blank = 1'b1;
    while (n < 144) begin
      step();
      check_scan("blank", 16'h145B, 1'b0, 0, 1'b1);
    end
    blank = 1'b0;
    while (n < 166) begin
      step();
      check_scan("unblank", 16'h145B, 1'b0, 0, 1'b0);
    end

    // One-cycle reset mid-frame.
    rst = 1'b1;
    step();
    n = 0;
    check_eq("mrst_an", an, 4'hF);
    check_eq("mrst_seg", seg, 7'h7F);
    check_eq("mrst_fd", frame_done, 1'b0);
    check_eq("mrst_an2", an2, 5'h1F);
    rst = 1'b0;
    while (n < 32) begin
      step();
      check_scan("postrst", 16'h0000, 1'b0, 0, 1'b0);
      // Second instance: cursor at 7 with only five digits is never dark.
      ea2 = ~(5'b00001 << ((n - 1) % 5));
      check_eq("cur7_an2", an2, ea2);
      check_eq("cur7_seg2", seg2, 7'h40);
      check_eq("cur7_fd2", frame_done2, (n % 5) == 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
